poly_envelope: RTL

Time-multiplexed polyphonic ADSR envelope and mixer. It is the successor to the single-voice envelope stage and is parametrised in voice count and data width. Each voice has its own ADSR state machine clocked by a slow tick. On every audio sample strobe, a sequential multiply-accumulate (MAC) scales each voice's signal by its envelope, sums all voices and delivers one mixed sample to the I2S transmitter.

---
 rtl/poly_envelope.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/poly_envelope.sv
// Polyphonic ADSR envelope with a sequential multiply-accumulate mixer.
// Optional build macro POLY_ENV_SCALE_EN: scale the final mix by 1/VOICES instead of saturating.
module poly_envelope #(
    parameter int DATA_WIDTH = 16,
    parameter int VOICES     = 4,
    parameter int FACTOR_W   = 5
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    input  logic                         tick_i,
    input  logic                         sample_strobe_i,
    input  logic [VOICES-1:0]            gate_i,
    input  logic [VOICES*DATA_WIDTH-1:0] signal_i,
    input  logic [FACTOR_W-1:0]          attack_i,
    input  logic [FACTOR_W-1:0]          decay_i,
    input  logic [FACTOR_W-1:0]          sustain_i,
    input  logic [FACTOR_W-1:0]          release_i,
    output logic [DATA_WIDTH-1:0]        mix_o,
    output logic                         mix_valid_o,
    output logic                         busy_o,
    output logic [VOICES-1:0]            active_o
);

    localparam int IDX_W  = $clog2(VOICES);
    localparam int ACC_W  = DATA_WIDTH + IDX_W;
    localparam int ENV_W  = 16;
    localparam int PROD_W = DATA_WIDTH + ENV_W + 1;

    localparam logic signed [ACC_W-1:0] MIX_MAX = {{(IDX_W+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIX_MIN = {{(IDX_W+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    env_state_e                    state_q [VOICES];
    env_state_e                    state_d [VOICES];
    logic [VOICES-1:0][ENV_W-1:0]  env_q;
    logic [VOICES-1:0][ENV_W-1:0]  env_d;
    logic [ENV_W:0]                lvl [VOICES];
    logic [VOICES-1:0]             gate_q;

    logic [ENV_W:0]   step_a, step_d, step_r;
    logic [ENV_W-1:0] sus;

    always_comb begin
        step_a = (17'(attack_i)  + 17'd1) << 6;
        step_d = (17'(decay_i)   + 17'd1) << 6;
        step_r = (17'(release_i) + 17'd1) << 6;
        sus    = 16'(sustain_i) << (ENV_W - FACTOR_W);
    end

    // Gate transition resolves first; a same-cycle tick then applies the new state's step.
    always_comb begin
        for (int unsigned v = 0; v < VOICES; v++) begin
            state_d[v] = state_q[v];
            lvl[v]     = {1'b0, env_q[v]};
            if (gate_i[v] && !gate_q[v] && (state_q[v] == ST_IDLE || state_q[v] == ST_RELEASE)) begin
                state_d[v] = ST_ATTACK;
            end else if (!gate_i[v] && (state_q[v] == ST_ATTACK || state_q[v] == ST_DECAY ||
                                        state_q[v] == ST_SUSTAIN)) begin
                state_d[v] = ST_RELEASE;
            end
            if (tick_i) begin
                case (state_d[v])
                    ST_ATTACK: begin
                        lvl[v] = lvl[v] + step_a;
                        if (lvl[v] >= 17'h0FFFF) begin
                            lvl[v]     = 17'h0FFFF;
                            state_d[v] = ST_DECAY;
                        end
                    end
                    ST_DECAY: begin
                        if (lvl[v] < step_d || (lvl[v] - step_d) <= {1'b0, sus}) begin
                            lvl[v]     = {1'b0, sus};
                            state_d[v] = ST_SUSTAIN;
                        end else begin
                            lvl[v] = lvl[v] - step_d;
                        end
                    end
                    ST_SUSTAIN: lvl[v] = {1'b0, sus};
                    ST_RELEASE: begin
                        if (lvl[v] <= step_r) begin
                            lvl[v]     = '0;
                            state_d[v] = ST_IDLE;
                        end else begin
                            lvl[v] = lvl[v] - step_r;
                        end
                    end
                    default: ;
                endcase
            end
            env_d[v] = lvl[v][ENV_W-1:0];
        end
    end

    logic                        busy_q, busy_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [DATA_WIDTH-1:0]       mix_q, mix_d;
    logic                        valid_q, valid_d;

    logic signed [DATA_WIDTH-1:0] sig_sel;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      prod_term;
    logic signed [ACC_W-1:0]      acc_sum;
    logic [DATA_WIDTH-1:0]        mix_red;

    always_comb begin
        sig_sel   = signal_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        prod      = sig_sel * $signed({1'b0, env_q[idx_q]});
        prod_term = ACC_W'(prod >>> ENV_W);
        acc_sum   = acc_q + prod_term;
`ifdef POLY_ENV_SCALE_EN
        mix_red   = DATA_WIDTH'(acc_sum >>> IDX_W);
`else
        if (acc_sum > MIX_MAX) begin
            mix_red = MIX_MAX[DATA_WIDTH-1:0];
        end else if (acc_sum < MIX_MIN) begin
            mix_red = MIX_MIN[DATA_WIDTH-1:0];
        end else begin
            mix_red = acc_sum[DATA_WIDTH-1:0];
        end
`endif
    end

    always_comb begin
        busy_d  = busy_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mix_d   = mix_q;
        valid_d = 1'b0;
        if (busy_q) begin
            acc_d = acc_sum;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(VOICES - 1)) begin
                busy_d  = 1'b0;
                idx_d   = '0;
                mix_d   = mix_red;
                valid_d = 1'b1;
            end
        end else if (sample_strobe_i) begin
            busy_d = 1'b1;
            idx_d  = '0;
            acc_d  = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                state_q[v] <= ST_IDLE;
            end
            env_q   <= '0;
            gate_q  <= '0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            mix_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                state_q[v] <= state_d[v];
            end
            env_q   <= env_d;
            gate_q  <= gate_i;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mix_q   <= mix_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int unsigned v = 0; v < VOICES; v++) begin
            active_o[v] = (state_q[v] != ST_IDLE);
        end
    end

    assign mix_o       = mix_q;
    assign mix_valid_o = valid_q;
    assign busy_o      = busy_q;

endmodule
